// File: rtl/rom_stream_reader_pkg.sv
// rom_stream_reader_pkg: shared state encoding and default widths for the ROM stream reader
package rom_stream_reader_pkg;
  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;
endpackage

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a wrapping burst of ROM addresses and streams the words on valid/ready
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  state_t state, state_nxt;
  logic [ADDR_W:0] rem;
  logic go, zero_start, load, accept, finish, rem_one;
  assign busy = state != ST_IDLE;
  // load fills the output slot whenever it is empty or being drained this cycle
  always_comb begin
    go         = state == ST_IDLE && start && length != '0;
    zero_start = state == ST_IDLE && start && length == '0;
    load       = state == ST_STREAM && (!out_valid || out_ready);
    accept     = out_valid && out_ready;
    finish     = state == ST_DRAIN && accept && out_last;
    rem_one    = rem == (ADDR_W+1)'(1);
    state_nxt  = go ? ST_STREAM : (load && rem_one) ? ST_DRAIN : finish ? ST_IDLE : state;
  end
  // state register, address/remaining counters and the registered output slot
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rom_addr  <= '0;
      rem       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= zero_start || finish;
      if (go) begin
        rom_addr <= start_addr;
        rem      <= length;
      end
      if (load) begin
        out_data  <= rom_data;
        out_valid <= 1'b1;
        out_last  <= rem_one;
        rom_addr  <= rom_addr + ADDR_W'(1);
        rem       <= rem - (ADDR_W+1)'(1);
      end else if (accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule
